spi_modport: RTL and testbench

Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with an embedded SPI slave endpoint on the same serial bus. It sits between a byte-level host handshake (start/busy/done) and the serial pins. The embedded slave makes loopback and mirror checks possible inside one block: it captures MOSI and returns a preloaded byte.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_slave_ep.sv | 56 +++++
 rtl/spi_modport.sv | 145 ++++++++++++++
 tb/tb_spi_modport.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master with embedded slave endpoint.
// Holds the transfer FSM state type and the default geometry of a transfer
// (bits per transfer, clk cycles per SCLK half-period).
package spi_pkg;

  // Master FSM: waiting for a start request, or shifting a byte out/in.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int CLK_DIV_DEF = 2;

endpackage

// File: rtl/spi_slave_ep.sv
// Embedded SPI slave endpoint, mode 0, MSB first.
// It runs entirely on clk: the master hands it one-cycle strobes marking the
// SCLK rising and falling edges instead of clocking anything from sclk.
// Ports:
//   clk, rst_n      system clock, synchronous active-high reset
//   sclk_rise       strobe: sample mosi this cycle
//   sclk_fall       strobe: advance the send shift register
//   cs_n            active-low select; the endpoint is inert while high
//   mosi            serial data from the master
//   load            strobe: capture send_data at the start of a transfer
//   send_data       byte returned to the master
//   out_bit         serial bit the endpoint drives toward the master
//   rx_byte         bits received so far (a full byte after the last rise)
module spi_slave_ep
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              load,
  input  logic [DATA_W-1:0] send_data,
  output logic              out_bit,
  output logic [DATA_W-1:0] rx_byte
);

  logic [DATA_W-1:0] send_shift;
  logic [DATA_W-1:0] rx_shift;

  // Capture the reply byte on load, then shift it left one bit per SCLK fall
  // and collect mosi MSB first on every SCLK rise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      send_shift <= '0;
      rx_shift   <= '0;
    end else if (load) begin
      send_shift <= send_data;
    end else if (!cs_n) begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi};
      end
      if (sclk_fall) begin
        send_shift <= {send_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Deselected, the endpoint drives 0 so it cannot disturb the wired-OR MISO.
  assign out_bit = !cs_n && send_shift[DATA_W-1];
  assign rx_byte = rx_shift;

endmodule

// File: rtl/spi_modport.sv
// Byte-wide SPI master, mode 0, MSB first, with an embedded slave endpoint
// sharing the serial bus, so loopback works without external wiring.
// Ports:
//   clk, rst_n          system clock, synchronous active-high reset
//   start               request a transfer (only honoured in IDLE)
//   tx_data             byte to send, captured on an accepted start
//   rx_data             byte received by the master, updated on done
//   busy, done          transfer in progress / one-cycle completion pulse
//   sclk, mosi, cs_n    serial clock (idles low), master out, chip select
//   miso                external serial input, ORed with the endpoint's bit
//   slave_rx_data       byte received by the endpoint, updated on done
//   slave_send_data     byte the endpoint returns, captured on start
module spi_modport
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic [DATA_W-1:0] slave_rx_data,
  input  logic [DATA_W-1:0] slave_send_data
);

  // Sized so CLK_DIV=1 still yields a legal one-bit counter.
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              start_ok;
  logic              div_tc;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              last_fall;
  logic              slave_out_bit;
  logic              miso_eff;
  logic [DATA_W-1:0] slave_rx_byte;

  assign start_ok  = (state == IDLE) && start;
  // The divider expiring marks an SCLK edge; the current sclk level says which.
  assign div_tc    = (state == XFER) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sclk_rise = div_tc && !sclk;
  assign sclk_fall = div_tc && sclk;
  assign last_fall = sclk_fall && (bit_cnt == CNT_W'(DATA_W - 1));
  // The endpoint drives 0 when idle, so an external slave can share the line.
  assign miso_eff  = miso | slave_out_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a transfer ends on the falling edge of its last bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = XFER;
      XFER: if (last_fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs that follow the state directly; mosi is forced low when idle.
  always_comb begin
    busy = (state == XFER);
    cs_n = (state != XFER);
    mosi = (state == XFER) && tx_shift[DATA_W-1];
  end

  // Divider, bit counter, master shift registers and the result registers.
  // The receive register already holds all bits at the last fall because the
  // final rise came CLK_DIV cycles earlier.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      sclk          <= 1'b0;
      done          <= 1'b0;
      rx_data       <= '0;
      slave_rx_data <= '0;
    end else begin
      done <= last_fall;
      if (start_ok) begin
        tx_shift <= tx_data;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        sclk     <= 1'b0;
      end else if (state == XFER) begin
        if (div_tc) begin
          div_cnt <= '0;
          sclk    <= !sclk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (sclk_rise) begin
          rx_shift <= {rx_shift[DATA_W-2:0], miso_eff};
        end
        if (sclk_fall) begin
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (last_fall) begin
          rx_data       <= rx_shift;
          slave_rx_data <= slave_rx_byte;
        end
      end
    end
  end

  spi_slave_ep #(
    .DATA_W(DATA_W)
  ) u_slave (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .load     (start_ok),
    .send_data(slave_send_data),
    .out_bit  (slave_out_bit),
    .rx_byte  (slave_rx_byte)
  );

endmodule

// File: tb/tb_spi_modport.sv
// Self-checking bench for spi_modport: each task exercises one scenario and
// checks the DUT against expectations derived from the transfer rules
// (master receives miso OR slave byte, slave receives tx byte, fixed latency).
module tb_spi_modport;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int DONE_AT = 1 + 2 * DATA_W * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              miso = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [DATA_W-1:0] slave_send_data = '0;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] slave_rx_data;
  logic              busy, done, sclk, mosi, cs_n;

  int checks = 0;
  int failures = 0;

  spi_modport #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .tx_data        (tx_data),
    .rx_data        (rx_data),
    .busy           (busy),
    .done           (done),
    .sclk           (sclk),
    .mosi           (mosi),
    .miso           (miso),
    .cs_n           (cs_n),
    .slave_rx_data  (slave_rx_data),
    .slave_send_data(slave_send_data)
  );

  always #5 clk = ~clk;

  // Result of one observed transfer.
  int          r_done_at;
  int          r_rises;
  logic [7:0]  r_mosi_seq;
  logic [7:0]  r_rx;
  logic [7:0]  r_srx;
  logic        r_cs_ok;
  logic        r_first_cs;
  logic        r_cs_at_done;

  // Drives one transfer from the current negedge and watches it until done or
  // a cycle budget runs out. mb is bit-banged on miso, changing on falls.
  // A nonzero restart_at re-pulses start with other data in that cycle.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] ss,
                          input logic [7:0] mb, input int restart_at,
                          input logic [7:0] tx2);
    int   fall_idx;
    logic prev;
    fall_idx = 0;
    prev = 1'b0;
    r_done_at = 0;
    r_rises = 0;
    r_mosi_seq = '0;
    r_rx = '0;
    r_srx = '0;
    r_cs_ok = 1'b1;
    r_first_cs = 1'b1;
    r_cs_at_done = 1'b0;
    tx_data = tx;
    slave_send_data = ss;
    miso = mb[7];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= DONE_AT + 8; n++) begin
      if (n == 1) r_first_cs = cs_n;
      if (sclk && !prev) begin
        r_rises++;
        r_mosi_seq = {r_mosi_seq[6:0], mosi};
      end
      if (!sclk && prev) begin
        fall_idx++;
        miso = (fall_idx < 8) ? mb[3'(7 - fall_idx)] : 1'b0;
      end
      prev = sclk;
      if (done) begin
        r_done_at = n;
        r_rx = rx_data;
        r_srx = slave_rx_data;
        r_cs_at_done = cs_n;
        break;
      end
      if (cs_n || !busy) r_cs_ok = 1'b0;
      if (n == restart_at) begin
        start = 1'b1;
        tx_data = tx2;
        slave_send_data = ~ss;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    miso = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (slave_rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_slave_rx: got %h expected 00", slave_rx_data); end
  endtask

  task automatic test_reset_mid();
    int   rises;
    int   dones;
    logic prev;
    rises = 0;
    dones = 0;
    prev = 1'b0;
    tx_data = 8'h5A;
    slave_send_data = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < DONE_AT && rises < 4; n++) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises < 4) @(negedge clk);
    end
    checks++; if (rises != 4) begin failures++; $display("[TB] FAIL mid_reset_rises: got %0d expected 4", rises); end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    checks++; if (cs_n !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_cs_n: got %b expected 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_sclk: got %b expected 0", sclk); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
    for (int n = 0; n < DONE_AT + 4; n++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin failures++; $display("[TB] FAIL mid_reset_done: got %0d pulses expected 0", dones); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_rx: got %h expected 00", rx_data); end
  endtask

  // Loopback: miso held low, so master gets the slave byte and vice versa.
  task automatic test_loopback();
    logic [7:0] tx, ss;
    for (int i = 0; i < 6; i++) begin
      tx = (i == 0) ? 8'hA5 : 8'($urandom);
      ss = (i == 0) ? 8'h3C : 8'($urandom);
      @(negedge clk);
      run_xfer(tx, ss, 8'h00, 0, 8'h00);
      checks++; if (r_done_at != DONE_AT) begin failures++; $display("[TB] FAIL loop_done_at: got %0d expected %0d", r_done_at, DONE_AT); end
      checks++; if (r_rx !== ss) begin failures++; $display("[TB] FAIL loop_rx: got %h expected %h", r_rx, ss); end
      checks++; if (r_srx !== tx) begin failures++; $display("[TB] FAIL loop_slave_rx: got %h expected %h", r_srx, tx); end
      checks++; if (r_mosi_seq !== tx) begin failures++; $display("[TB] FAIL loop_mosi_seq: got %h expected %h", r_mosi_seq, tx); end
      checks++; if (!r_cs_ok || r_cs_at_done !== 1'b1) begin failures++; $display("[TB] FAIL loop_cs_busy: window_ok=%b cs_at_done=%b expected 1/1", r_cs_ok, r_cs_at_done); end
    end
  endtask

  // External MISO and the wired-OR with the slave byte.
  task automatic test_external_miso();
    logic [7:0] tx, ss, mb;
    for (int i = 0; i < 5; i++) begin
      tx = 8'($urandom);
      mb = (i == 0) ? 8'h96 : 8'($urandom);
      ss = (i < 2) ? 8'h00 : 8'($urandom);
      @(negedge clk);
      run_xfer(tx, ss, mb, 0, 8'h00);
      checks++; if (r_rx !== (mb | ss)) begin failures++; $display("[TB] FAIL ext_rx: got %h expected %h", r_rx, mb | ss); end
      checks++; if (r_rises != 8) begin failures++; $display("[TB] FAIL ext_sclk_pulses: got %0d expected 8", r_rises); end
      checks++; if (r_srx !== tx) begin failures++; $display("[TB] FAIL ext_slave_rx: got %h expected %h", r_srx, tx); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] tx, ss, tx2;
    int dones;
    tx = 8'($urandom);
    ss = 8'($urandom);
    tx2 = ~tx;
    dones = 0;
    @(negedge clk);
    run_xfer(tx, ss, 8'h00, 10, tx2);
    checks++; if (r_done_at != DONE_AT) begin failures++; $display("[TB] FAIL busy_done_at: got %0d expected %0d", r_done_at, DONE_AT); end
    checks++; if (r_srx !== tx) begin failures++; $display("[TB] FAIL busy_slave_rx: got %h expected %h", r_srx, tx); end
    checks++; if (r_rx !== ss) begin failures++; $display("[TB] FAIL busy_rx: got %h expected %h", r_rx, ss); end
    for (int n = 0; n < DONE_AT + 4; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("[TB] FAIL busy_extra_activity: got %0d cycles expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ss1, ss2, rx1, srx1;
    logic cs_gap;
    ss1 = 8'($urandom);
    ss2 = 8'($urandom);
    @(negedge clk);
    run_xfer(8'hFF, ss1, 8'h00, 0, 8'h00);
    rx1 = r_rx;
    srx1 = r_srx;
    cs_gap = r_cs_at_done;
    run_xfer(8'h00, ss2, 8'h00, 0, 8'h00);
    checks++; if (rx1 !== ss1 || srx1 !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_first: got rx=%h srx=%h expected rx=%h srx=ff", rx1, srx1, ss1); end
    checks++; if (cs_gap !== 1'b1 || r_first_cs !== 1'b0) begin failures++; $display("[TB] FAIL b2b_cs_gap: got done_cs=%b next_cs=%b expected 1/0", cs_gap, r_first_cs); end
    checks++; if (r_done_at != DONE_AT) begin failures++; $display("[TB] FAIL b2b_done_at: got %0d expected %0d", r_done_at, DONE_AT); end
    checks++; if (r_rx !== ss2 || r_srx !== 8'h00) begin failures++; $display("[TB] FAIL b2b_second: got rx=%h srx=%h expected rx=%h srx=00", r_rx, r_srx, ss2); end
    @(negedge clk);
    checks++; if (rx_data !== ss2) begin failures++; $display("[TB] FAIL b2b_hold: got %h expected %h", rx_data, ss2); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_loopback();
    test_external_miso();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
